// File: rtl/memory_access_pkg.sv
// Shared constants, opcode/funct3 codes and the lane-alignment payload for memory_access.
package memory_access_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = 8;

  // Major opcodes, ir[6:0]
  localparam logic [6:0] DECODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] DECODE_I_TYPE = 7'b0010011;
  localparam logic [6:0] DECODE_L_TYPE = 7'b0000011;
  localparam logic [6:0] DECODE_S_TYPE = 7'b0100011;

  // Access width codes, ir[14:12]
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Result of lane alignment for one access
  typedef struct packed {
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata_ext;
    logic            misaligned;
    logic            bad_f3;
  } align_t;

  // True when funct3 names a supported width for the given access direction
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational byte-lane steering: byte enables, store replication, load extraction/extension.
module mem_align
  import memory_access_pkg::*;
(
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_st_data,
  input  logic [XLEN-1:0] i_rdata,
  output align_t          o_align
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_legal;

  // Pick the addressed byte and half-word out of the read word
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Width-dependent enables, replication, extension and alignment check
  always_comb begin
    o_align = '0;
    w_legal = (i_is_load | i_is_store) & f3_legal(i_is_load, i_funct3);
    case (i_funct3[1:0])
      2'b00: begin
        o_align.be        = 4'b0001 << i_addr_lo;
        o_align.wdata     = {4{i_st_data[7:0]}};
        o_align.rdata_ext = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        o_align.be         = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_align.wdata      = {2{i_st_data[15:0]}};
        o_align.rdata_ext  = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        o_align.misaligned = w_legal & i_addr_lo[0];
      end
      2'b10: begin
        o_align.be         = 4'b1111;
        o_align.wdata      = i_st_data;
        o_align.rdata_ext  = i_rdata;
        o_align.misaligned = w_legal & (|i_addr_lo);
      end
      default: begin
        o_align.be = '0;
      end
    endcase
    o_align.bad_f3 = (i_is_load | i_is_store) & ~w_legal;
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: passes ALU ops through, runs loads/stores on a req/ack data bus with timeout.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] ir_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [BE_W-1:0] bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic [XLEN-1:0] bus_rdata_i,
  input  logic            bus_ack_i,
  output logic            wd_q_readin_o,
  output logic [XLEN-1:0] wd_o,
  output logic [XLEN-1:0] mem_o,
  output logic [XLEN-1:0] ir_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rs2;

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [1:0]       w_addr_lo;
  logic             w_is_load;
  logic             w_is_store;
  logic [CNT_W:0]   w_cnt_next;
  logic             w_timeout;
  align_t           w_align;

  // Decode the incoming instruction while idle, the captured one otherwise
  always_comb begin
    w_opcode   = (r_state == S_IDLE) ? ir_i[6:0]   : ir_o[6:0];
    w_funct3   = (r_state == S_IDLE) ? ir_i[14:12] : ir_o[14:12];
    w_addr_lo  = (r_state == S_IDLE) ? alu_i[1:0]  : wd_o[1:0];
    w_is_load  = (w_opcode == DECODE_L_TYPE);
    w_is_store = (w_opcode == DECODE_S_TYPE);
    w_cnt_next = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(1);
    w_timeout  = (w_cnt_next >= (CNT_W+1)'(TIMEOUT));
  end

  mem_align u_mem_align (
    .i_is_load  (w_is_load),
    .i_is_store (w_is_store),
    .i_funct3   (w_funct3),
    .i_addr_lo  (w_addr_lo),
    .i_st_data  (rs2_i),
    .i_rdata    (bus_rdata_i),
    .o_align    (w_align)
  );

  // Stage FSM with registered bus and writeback outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rs2         <= '0;
      ready_o       <= 1'b1;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_be_o      <= '0;
      bus_wdata_o   <= '0;
      wd_q_readin_o <= 1'b0;
      wd_o          <= '0;
      mem_o         <= '0;
      ir_o          <= '0;
      pc_o          <= '0;
      fault_o       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            ir_o    <= ir_i;
            pc_o    <= pc_i;
            wd_o    <= alu_i;
            r_rs2   <= rs2_i;
            mem_o   <= '0;
            r_cnt   <= '0;
            ready_o <= 1'b0;
            if ((w_is_load | w_is_store) & ~w_align.misaligned & ~w_align.bad_f3) begin
              r_state     <= S_BUS;
              bus_req_o   <= 1'b1;
              bus_we_o    <= w_is_store;
              bus_addr_o  <= {alu_i[XLEN-1:2], 2'b00};
              bus_be_o    <= w_align.be;
              bus_wdata_o <= w_is_store ? w_align.wdata : '0;
            end else begin
              r_state       <= S_DONE;
              wd_q_readin_o <= 1'b1;
              fault_o       <= w_is_load | w_is_store;
            end
          end
        end
        S_BUS: begin
          if (bus_ack_i) begin
            r_state       <= S_DONE;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            wd_q_readin_o <= 1'b1;
            mem_o         <= w_is_store ? r_rs2 : w_align.rdata_ext;
          end else if (w_timeout) begin
            r_state       <= S_DONE;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            wd_q_readin_o <= 1'b1;
            fault_o       <= 1'b1;
          end else begin
            r_cnt <= w_cnt_next[CNT_W-1:0];
          end
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          wd_q_readin_o <= 1'b0;
          fault_o       <= 1'b0;
          ready_o       <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized checks of memory_access against a behavioural transaction model.
module tb_memory_access;

  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] ir_i, pc_i, alu_i, rs2_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i;
  logic        wd_q_readin_o;
  logic [31:0] wd_o, mem_o, ir_o, pc_o;
  logic        fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .ir_i(ir_i), .pc_i(pc_i), .alu_i(alu_i), .rs2_i(rs2_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .wd_q_readin_o(wd_q_readin_o), .wd_o(wd_o),
    .mem_o(mem_o), .ir_o(ir_o), .pc_o(pc_o), .fault_o(fault_o)
  );

  typedef struct {
    bit          memop;
    bit          use_bus;
    bit          fault;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // What one instruction should do, from opcode/funct3/address rules in plain arithmetic
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [31:0] rdata);
    exp_t   e;
    int     sz, off;
    bit     sgn, ld, st, ok;
    longint v, lim;
    e = '{default: '0};
    ld = (ir[6:0] == 7'h03);
    st = (ir[6:0] == 7'h23);
    e.memop = ld || st;
    if (!e.memop) return e;
    ok = 1; sgn = 0; sz = 1;
    case (ir[14:12])
      3'd0:    begin sz = 1; sgn = 1; end
      3'd1:    begin sz = 2; sgn = 1; end
      3'd2:    sz = 4;
      3'd4:    begin sz = 1; ok = ld; end
      3'd5:    begin sz = 2; ok = ld; end
      default: ok = 0;
    endcase
    off = int'(alu[1:0]);
    if (!ok || (off % sz) != 0) begin
      e.fault = 1;
      return e;
    end
    e.use_bus = 1;
    e.we      = st;
    e.addr    = alu & 32'hFFFF_FFFC;
    e.be      = 4'(((1 << sz) - 1) << off);
    if (st) begin
      if (sz == 1)      e.wdata = rs2[7:0] * 32'h0101_0101;
      else if (sz == 2) e.wdata = rs2[15:0] * 32'h0001_0001;
      else              e.wdata = rs2;
      e.mem = rs2;
    end else begin
      v   = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
      lim = 64'd1 << (8 * sz - 1);
      if (sgn && v >= lim) v = v - 2 * lim;
      e.mem = 32'(v);
    end
    return e;
  endfunction

  // Issue one instruction, service the bus with an ack after ack_d BUS cycles, check the result
  task automatic run_txn(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int ack_d);
    exp_t e;
    int   hi, exp_cyc;
    bit   exp_fault;
    logic [31:0] exp_mem;
    e = model(ir, alu, rs2, rdata);
    chk("ready_idle", 32'(ready_o), 32'd1);
    valid_i = 1'b1; ir_i = ir; pc_i = pc; alu_i = alu; rs2_i = rs2;
    bus_rdata_i = rdata; bus_ack_i = 1'($urandom);
    step();
    valid_i = 1'b0; ir_i = $urandom; pc_i = $urandom; alu_i = $urandom; rs2_i = $urandom;
    chk("ready_busy", 32'(ready_o), 32'd0);
    exp_fault = e.fault;
    exp_mem   = e.mem;
    if (e.use_bus) begin
      chk("bus_req", 32'(bus_req_o), 32'd1);
      chk("bus_we", 32'(bus_we_o), 32'(e.we));
      chk("bus_addr", bus_addr_o, e.addr);
      chk("bus_be", 32'(bus_be_o), 32'(e.be));
      if (e.we) chk("bus_wdata", bus_wdata_o, e.wdata);
      hi = 0;
      while (bus_req_o === 1'b1 && hi < 1000) begin
        bus_ack_i = (hi == ack_d);
        step();
        hi++;
      end
      bus_ack_i = 1'b0;
      exp_cyc = (ack_d < int'(TMO)) ? ack_d + 1 : int'(TMO);
      chk("bus_cycles", 32'(hi), 32'(exp_cyc));
      if (ack_d >= int'(TMO)) begin
        exp_fault = 1;
        exp_mem   = '0;
      end
    end
    chk("done_strobe", 32'(wd_q_readin_o), 32'd1);
    chk("done_fault", 32'(fault_o), 32'(exp_fault));
    chk("done_no_req", 32'(bus_req_o), 32'd0);
    chk("wd_o", wd_o, alu);
    chk("ir_o", ir_o, ir);
    chk("pc_o", pc_o, pc);
    if (e.memop) chk("mem_o", mem_o, exp_mem);
    bus_ack_i = 1'($urandom);
    step();
    bus_ack_i = 1'b0;
    chk("strobe_off", 32'(wd_q_readin_o), 32'd0);
    chk("fault_off", 32'(fault_o), 32'd0);
    chk("ready_back", 32'(ready_o), 32'd1);
    chk("wd_hold", wd_o, alu);
    if (e.memop) chk("mem_hold", mem_o, exp_mem);
  endtask

  initial begin
    logic [31:0] ir;
    logic [6:0]  ops [5];
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h37;

    reset = 1'b1; valid_i = 1'b0; ir_i = '0; pc_i = '0; alu_i = '0; rs2_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
    step(); step();
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_strobe", 32'(wd_q_readin_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_be", 32'(bus_be_o), 32'd0);
    chk("rst_wd", wd_o, 32'd0);
    chk("rst_mem", mem_o, 32'd0);
    reset = 1'b0;
    step();

    // R-type pass-through
    run_txn(32'h0020_81B3, 32'h0000_1000, 32'h0000_0010, 32'hDEAD_BEEF, $urandom, 0);
    // LB from top byte, sign-extended
    run_txn(32'h0000_0083, 32'h0000_1004, 32'h0000_0103, 32'h0, 32'h8012_3456, 3);
    chk("lb_mem_const", mem_o, 32'hFFFF_FF80);
    // SH to upper half
    run_txn(32'h0000_1023, 32'h0000_1008, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1);
    chk("sh_mem_const", mem_o, 32'h1234_ABCD);
    // Misaligned LW
    run_txn(32'h0000_2003, 32'h0000_100C, 32'h0000_0101, 32'h0, 32'h0, 0);
    // Unsupported store width
    run_txn(32'h0000_3023, 32'h0000_1010, 32'h0000_0300, 32'h5555_AAAA, 32'h0, 0);
    // Ack never comes: timeout
    run_txn(32'h0000_2003, 32'h0000_1014, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, int'(TMO));
    // Ack on the very last allowed cycle: success
    run_txn(32'h0000_2003, 32'h0000_1018, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, int'(TMO) - 1);
    chk("late_ack_mem", mem_o, 32'hCAFE_F00D);
    // LHU / LBU zero extension
    run_txn(32'h0000_5003, 32'h0000_101C, 32'h0000_0502, 32'h0, 32'hF00D_1234, 2);
    run_txn(32'h0000_4003, 32'h0000_1020, 32'h0000_0501, 32'h0, 32'h0000_9A00, 0);

    // Reset in the middle of a bus transfer
    valid_i = 1'b1; ir_i = 32'h0000_2003; pc_i = 32'h0000_2000; alu_i = 32'h0000_0600;
    step();
    valid_i = 1'b0;
    chk("mid_req_up", 32'(bus_req_o), 32'd1);
    step(); step();
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus_req_o), 32'd0);
    chk("mid_rst_we", 32'(bus_we_o), 32'd0);
    chk("mid_rst_addr", bus_addr_o, 32'd0);
    chk("mid_rst_be", 32'(bus_be_o), 32'd0);
    chk("mid_rst_wdata", bus_wdata_o, 32'd0);
    chk("mid_rst_ir", ir_o, 32'd0);
    chk("mid_rst_pc", pc_o, 32'd0);
    chk("mid_rst_wd", wd_o, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_ack_i = 1'b1;
      step();
      chk("post_rst_strobe", 32'(wd_q_readin_o), 32'd0);
      chk("post_rst_req", 32'(bus_req_o), 32'd0);
    end
    bus_ack_i = 1'b0;

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      ir = $urandom;
      ir[6:0] = ops[$urandom_range(0, 4)];
      run_txn(ir, $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
